fifo_checker: RTL and testbench

Synthesizable, parametrised in-line checker for the team's FIFO. It sits beside a FIFO instance and taps the FIFO's input and output signals. It runs a cycle-accurate reference model (shadow storage, pointers, occupancy) and compares every FIFO output against the model each clock. Results are kept in saturating correct/error counters, a sticky mismatch vector and an optional first-error snapshot, so the same checks run in simulation, emulation and FPGA bring-up.

---
 rtl/fifo_checker_if.sv | 33 +++
 rtl/fifo_checker.sv | 134 +++++++++++++
 tb/tb_fifo_checker.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_checker_if.sv
// Tap bundle between an observed FIFO and its in-line checker.
// master drives the taps (FIFO side or bench), slave observes them.
interface fifo_checker_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dut_data_out;
    logic                  dut_wr_ack;
    logic                  dut_overflow;
    logic                  dut_underflow;
    logic                  dut_full;
    logic                  dut_empty;
    logic                  dut_almostfull;
    logic                  dut_almostempty;

    modport master (
        output data_in, wr_en, rd_en,
        output dut_data_out, dut_wr_ack,
        output dut_overflow, dut_underflow,
        output dut_full, dut_empty,
        output dut_almostfull, dut_almostempty
    );

    modport slave (
        input data_in, wr_en, rd_en,
        input dut_data_out, dut_wr_ack,
        input dut_overflow, dut_underflow,
        input dut_full, dut_empty,
        input dut_almostfull, dut_almostempty
    );
endinterface

// File: rtl/fifo_checker.sv
// Cycle-accurate FIFO reference model with saturating statistics.
// Define FIFO_CHECKER_FIRST_ERR_EN to build the first-error snapshot.
module fifo_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_checker_if.slave         tap,
    output logic [CNT_WIDTH-1:0]  correct_count,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic                  err_pulse,
    output logic [7:0]            err_vec,
    output logic                  first_err_valid,
    output logic [CNT_WIDTH-1:0]  first_err_cycle,
    output logic [7:0]            first_err_vec,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_act
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [DATA_WIDTH-1:0] exp_data_out;
    logic                  exp_wr_ack;
    logic                  exp_overflow;
    logic                  exp_underflow;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [7:0]            mismatch;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v
    );
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        wr_acc = tap.wr_en && (count != FULL_CNT);
        rd_acc = tap.rd_en && (count != '0);
        mismatch = {
            tap.dut_almostempty != (count == ONE_CNT),
            tap.dut_almostfull  != (count == AF_CNT),
            tap.dut_empty       != (count == '0),
            tap.dut_full        != (count == FULL_CNT),
            tap.dut_underflow   != exp_underflow,
            tap.dut_overflow    != exp_overflow,
            tap.dut_wr_ack      != exp_wr_ack,
            tap.dut_data_out    != exp_data_out
        };
    end

    // Storage has no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= tap.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            exp_data_out  <= '0;
            exp_wr_ack    <= 1'b0;
            exp_overflow  <= 1'b0;
            exp_underflow <= 1'b0;
            correct_count <= '0;
            error_count   <= '0;
            err_pulse     <= 1'b0;
            err_vec       <= '0;
        end else begin
            exp_wr_ack    <= wr_acc;
            exp_overflow  <= tap.wr_en && (count == FULL_CNT);
            exp_underflow <= tap.rd_en && (count == '0);
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                exp_data_out <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
            if (mismatch == '0) begin
                correct_count <= sat_inc(correct_count);
            end else begin
                error_count <= sat_inc(error_count);
            end
            err_pulse <= |mismatch;
            err_vec   <= err_vec | mismatch;
        end
    end

`ifdef FIFO_CHECKER_FIRST_ERR_EN
    logic [CNT_WIDTH-1:0] cycle_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_cycle <= '0;
            first_err_vec   <= '0;
            first_err_exp   <= '0;
            first_err_act   <= '0;
        end else begin
            cycle_count <= sat_inc(cycle_count);
            if (mismatch != '0 && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_cycle <= cycle_count;
                first_err_vec   <= mismatch;
                first_err_exp   <= exp_data_out;
                first_err_act   <= tap.dut_data_out;
            end
        end
    end
`else
    assign first_err_valid = 1'b0;
    assign first_err_cycle = '0;
    assign first_err_vec   = '0;
    assign first_err_exp   = '0;
    assign first_err_act   = '0;
`endif
endmodule

// File: tb/tb_fifo_checker.sv
// Bench for fifo_checker: a small compliant FIFO feeds the taps,
// expectations are queued by stimulus and compared by a monitor.
module tb_fifo_checker;
    localparam int DW = 16;
    localparam int CW = 8;

    localparam int F_CORRECT = 0;
    localparam int F_ERROR   = 1;
    localparam int F_PULSE   = 2;
    localparam int F_VEC     = 3;
    localparam int F_FVALID  = 4;
    localparam int F_FCYCLE  = 5;
    localparam int F_FVEC    = 6;
    localparam int F_FEXP    = 7;
    localparam int F_FACT    = 8;

    typedef struct {
        string       name;
        int          sel;
        int unsigned val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_checker_if #(.DATA_WIDTH(DW)) bus();

    logic [CW-1:0] correct_count;
    logic [CW-1:0] error_count;
    logic          err_pulse;
    logic [7:0]    err_vec;
    logic          first_err_valid;
    logic [CW-1:0] first_err_cycle;
    logic [7:0]    first_err_vec;
    logic [DW-1:0] first_err_exp;
    logic [DW-1:0] first_err_act;

    fifo_checker #(
        .DATA_WIDTH(DW),
        .DEPTH(8),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tap(bus.slave),
        .correct_count(correct_count),
        .error_count(error_count),
        .err_pulse(err_pulse),
        .err_vec(err_vec),
        .first_err_valid(first_err_valid),
        .first_err_cycle(first_err_cycle),
        .first_err_vec(first_err_vec),
        .first_err_exp(first_err_exp),
        .first_err_act(first_err_act)
    );

    always #5 clk = ~clk;

    // Compliant observed FIFO, with fault overlays on data_out and full.
    logic [DW-1:0] tmem [8];
    logic [2:0]    twp;
    logic [2:0]    trp;
    logic [3:0]    tcnt;
    logic [DW-1:0] tdout;
    logic          tack;
    logic          tovf;
    logic          tudf;
    logic          twa;
    logic          tra;
    logic          bad_data = 1'b0;
    logic          flip_full = 1'b0;

    assign twa = bus.wr_en && (tcnt != 4'd8);
    assign tra = bus.rd_en && (tcnt != 4'd0);

    always @(posedge clk) begin
        if (rst) begin
            twp   <= '0;
            trp   <= '0;
            tcnt  <= '0;
            tdout <= '0;
            tack  <= 1'b0;
            tovf  <= 1'b0;
            tudf  <= 1'b0;
        end else begin
            tack <= twa;
            tovf <= bus.wr_en && (tcnt == 4'd8);
            tudf <= bus.rd_en && (tcnt == 4'd0);
            if (twa) begin
                tmem[twp] <= bus.data_in;
                twp       <= twp + 3'd1;
            end
            if (tra) begin
                tdout <= tmem[trp];
                trp   <= trp + 3'd1;
            end
            if (twa && !tra) tcnt <= tcnt + 4'd1;
            if (!twa && tra) tcnt <= tcnt - 4'd1;
        end
    end

    assign bus.dut_data_out    = bad_data ? 16'hBEEF : tdout;
    assign bus.dut_wr_ack      = tack;
    assign bus.dut_overflow    = tovf;
    assign bus.dut_underflow   = tudf;
    assign bus.dut_full        = (tcnt == 4'd8) ^ flip_full;
    assign bus.dut_empty       = (tcnt == 4'd0);
    assign bus.dut_almostfull  = (tcnt == 4'd7);
    assign bus.dut_almostempty = (tcnt == 4'd1);

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int unsigned get_f(input int sel);
        case (sel)
            F_CORRECT: return int'(correct_count);
            F_ERROR:   return int'(error_count);
            F_PULSE:   return int'(err_pulse);
            F_VEC:     return int'(err_vec);
            F_FVALID:  return int'(first_err_valid);
            F_FCYCLE:  return int'(first_err_cycle);
            F_FVEC:    return int'(first_err_vec);
            F_FEXP:    return int'(first_err_exp);
            default:   return int'(first_err_act);
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            int unsigned got;
            e = exp_q.pop_front();
            got = get_f(e.sel);
            n_tests++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h",
                         e.name, got, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r,
                         input logic [DW-1:0] d);
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        step();
    endtask

    task automatic expect_v(input string n, input int sel,
                            input int unsigned v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_stats(input string n, input int unsigned c,
                                input int unsigned e, input int unsigned p,
                                input int unsigned v);
        expect_v({n, ".correct"}, F_CORRECT, c);
        expect_v({n, ".error"}, F_ERROR, e);
        expect_v({n, ".pulse"}, F_PULSE, p);
        expect_v({n, ".vec"}, F_VEC, v);
    endtask

    task automatic expect_first(input string n, input int unsigned cyc,
                                input int unsigned vec, input int unsigned ex,
                                input int unsigned act);
`ifdef FIFO_CHECKER_FIRST_ERR_EN
        expect_v({n, ".fvalid"}, F_FVALID, 1);
        expect_v({n, ".fcycle"}, F_FCYCLE, cyc);
        expect_v({n, ".fvec"}, F_FVEC, vec);
        expect_v({n, ".fexp"}, F_FEXP, ex);
        expect_v({n, ".fact"}, F_FACT, act);
`else
        expect_v({n, ".fvalid"}, F_FVALID, 0);
        expect_v({n, ".fcycle"}, F_FCYCLE, 0);
        expect_v({n, ".fvec"}, F_FVEC, 0);
        expect_v({n, ".fexp"}, F_FEXP, 0);
        expect_v({n, ".fact"}, F_FACT, 0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        rst = 1'b0;
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;

        // Reset state
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        expect_stats("reset", 0, 0, 0, 0);
        expect_v("reset.fvalid", F_FVALID, 0);
        rst = 1'b0;

        // Write 1..8 then read 8, then two idle edges: 18 compares
        for (int k = 1; k <= 8; k++) drive(1'b1, 1'b0, DW'(k));
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        expect_stats("fill_drain", 18, 0, 0, 0);

        // Overflow attempt on a full FIFO
        do_reset();
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, DW'(16'h20 + k));
        drive(1'b1, 1'b0, 16'h0FFF);
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, '0);
        expect_stats("overflow", 18, 0, 0, 0);

        // Simultaneous write and read on an empty FIFO
        do_reset();
        drive(1'b1, 1'b1, 16'h00AA);
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, '0);
        expect_stats("empty_wr_rd", 4, 0, 0, 0);

        // Corrupted data_out visible for one edge (compare cycle 4)
        do_reset();
        drive(1'b1, 1'b0, 16'h0001);
        drive(1'b1, 1'b0, 16'h0002);
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b1, '0);
        bad_data = 1'b1;
        drive(1'b0, 1'b0, '0);
        bad_data = 1'b0;
        expect_stats("bad_data", 4, 1, 1, 8'h01);
        expect_first("bad_data", 4, 8'h01, 16'h0002, 16'hBEEF);
        drive(1'b0, 1'b0, '0);
        expect_stats("bad_data_after", 5, 1, 0, 8'h01);

        // Pointer wrap at occupancy 6..8, including write+read when full
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, DW'(16'h100 + k));
        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0, 1:    drive(1'b1, 1'b0, DW'(16'h200 + i));
                2:       drive(1'b1, 1'b1, DW'(16'h300 + i));
                default: drive(1'b0, 1'b1, '0);
            endcase
        end
        for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, '0);
        expect_stats("wrap", 38, 1, 0, 8'h01);
        expect_first("wrap", 4, 8'h01, 16'h0002, 16'hBEEF);

        // Reset with 5 entries stored
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, DW'(16'h400 + k));
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        expect_stats("mid_reset", 0, 0, 0, 0);
        expect_v("mid_reset.fvalid", F_FVALID, 0);
        rst = 1'b0;
        drive(1'b0, 1'b0, '0);
        expect_stats("post_reset", 1, 0, 0, 0);

        // Full flag fault at compare cycle 1
        flip_full = 1'b1;
        drive(1'b0, 1'b0, '0);
        flip_full = 1'b0;
        expect_stats("full_fault", 1, 1, 1, 8'h10);
        expect_first("full_fault", 1, 8'h10, 0, 0);
        drive(1'b0, 1'b0, '0);
        expect_stats("full_fault_after", 2, 1, 0, 8'h10);

        // Counter saturation at all-ones
        do_reset();
        for (int k = 0; k < 300; k++) drive(1'b0, 1'b0, '0);
        expect_stats("saturate", 255, 0, 0, 0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
